matmul_seq_ctrl: RTL and testbench

Sequencer for the matrix-multiplier demo datapath. Loads an N×N matrix A and an N×N matrix B element-by-element over a valid/ready port. Computes C = A·B on a single shared multiply-accumulate unit, N cycles per result. Streams each C element out with row/column tags over a valid/ready port. Sits between the tt_um top-level pin mapping (ui_in/uio_in/uo_out) and the MAC datapath.

---
 rtl/matmul_pkg.sv | 19 +
 rtl/matmul_mac.sv | 51 +++++
 rtl/matmul_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matrix-multiply sequencer.
package matmul_pkg;

  localparam int unsigned N_DEF  = 2;
  localparam int unsigned DW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    EMIT
  } state_e;

  // Sum of N products of two DW-bit operands never overflows this width.
  function automatic int unsigned acc_width(input int unsigned n, input int unsigned dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Registered multiply-accumulate, one product per enabled cycle.
// Two's-complement operands when MATMUL_SIGNED_EN is defined, unsigned otherwise.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned ACC_W = acc_width(N_DEF, DW_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  output logic [ACC_W-1:0] acc_o
);

  localparam int unsigned PW = 2 * DW;

  logic [PW-1:0]    a_ext_c;
  logic [PW-1:0]    b_ext_c;
  logic [PW-1:0]    prod_c;
  logic [ACC_W-1:0] prod_ext_c;
  logic [ACC_W-1:0] acc_q;

`ifdef MATMUL_SIGNED_EN
  assign a_ext_c    = {{DW{a_i[DW-1]}}, a_i};
  assign b_ext_c    = {{DW{b_i[DW-1]}}, b_i};
  assign prod_ext_c = {{(ACC_W - PW){prod_c[PW-1]}}, prod_c};
`else
  assign a_ext_c    = {{DW{1'b0}}, a_i};
  assign b_ext_c    = {{DW{1'b0}}, b_i};
  assign prod_ext_c = ACC_W'(prod_c);
`endif

  // Low PW bits of the extended product are exact in both number systems.
  assign prod_c = a_ext_c * b_ext_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + prod_ext_c;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Load/compute/emit sequencer computing C = A*B on one shared MAC.
// Optional two's-complement arithmetic via MATMUL_SIGNED_EN (in matmul_mac).
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned ACC_W = acc_width(N, DW)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        a_in,
  input  logic [DW-1:0]        b_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data,
  output logic [$clog2(N)-1:0] out_row,
  output logic [$clog2(N)-1:0] out_col,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned AW = $clog2(N * N);

  state_e        state_q;
  logic [AW-1:0] k_q;
  logic [IW-1:0] i_q;
  logic [IW-1:0] j_q;
  logic [IW-1:0] kk_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          done_q;
  logic [DW-1:0] a_mem_q [N*N];
  logic [DW-1:0] b_mem_q [N*N];

  logic          accept_c;
  logic          handshake_c;
  logic          last_k_c;
  logic          last_kk_c;
  logic          last_ij_c;
  logic          mac_clr_c;
  logic          mac_en_c;
  logic [AW-1:0] a_idx_c;
  logic [AW-1:0] b_idx_c;

  assign accept_c    = ena && (state_q == LOAD) && in_valid;
  assign handshake_c = ena && (state_q == EMIT) && out_ready;
  assign last_k_c    = (k_q == AW'(N * N - 1));
  assign last_kk_c   = (kk_q == IW'(N - 1));
  assign last_ij_c   = (i_q == IW'(N - 1)) && (j_q == IW'(N - 1));

  // Accumulator starts clean for the first result and after every handshake.
  assign mac_clr_c = (accept_c && last_k_c) || handshake_c;
  assign mac_en_c  = ena && (state_q == COMPUTE);

  assign a_idx_c = AW'(i_q * N + kk_q);
  assign b_idx_c = AW'(kk_q * N + j_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      kk_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int unsigned x = 0; x < N * N; x++) begin
        a_mem_q[x] <= '0;
        b_mem_q[x] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (ena) begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q    <= LOAD;
              k_q        <= '0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
          LOAD: begin
            if (in_valid) begin
              a_mem_q[k_q] <= a_in;
              b_mem_q[k_q] <= b_in;
              if (last_k_c) begin
                state_q    <= COMPUTE;
                k_q        <= '0;
                i_q        <= '0;
                j_q        <= '0;
                kk_q       <= '0;
                in_ready_q <= 1'b0;
              end else begin
                k_q <= k_q + 1'b1;
              end
            end
          end
          COMPUTE: begin
            if (last_kk_c) begin
              kk_q        <= '0;
              state_q     <= EMIT;
              out_valid_q <= 1'b1;
            end else begin
              kk_q <= kk_q + 1'b1;
            end
          end
          EMIT: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              if (last_ij_c) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= COMPUTE;
                if (j_q == IW'(N - 1)) begin
                  j_q <= '0;
                  i_q <= i_q + 1'b1;
                end else begin
                  j_q <= j_q + 1'b1;
                end
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  matmul_mac #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (mac_clr_c),
    .en_i  (mac_en_c),
    .a_i   (a_mem_q[a_idx_c]),
    .b_i   (b_mem_q[b_idx_c]),
    .acc_o (out_data)
  );

  // Disabling the block must withdraw load acceptance in the same cycle.
  assign in_ready  = in_ready_q && ena;
  assign out_valid = out_valid_q;
  assign out_row   = i_q;
  assign out_col   = j_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl at N=2, DW=4.
module tb_matmul_seq_ctrl;

  localparam int unsigned N     = 2;
  localparam int unsigned DW    = 4;
  localparam int unsigned ACC_W = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    a_in = '0;
  logic [DW-1:0]    b_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_data;
  logic [0:0]       out_row;
  logic [0:0]       out_col;
  logic             busy;
  logic             done;

  int vectors = 0;
  int errors  = 0;

  matmul_seq_ctrl #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Element k of each matrix sits at bits [4k+3:4k] of the packed vector.
  task automatic load(input logic [15:0] av, input logic [15:0] bv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("load_ready", in_ready, 1);
      in_valid = 1'b1;
      a_in     = av[4*k +: 4];
      b_in     = bv[4*k +: 4];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Expects out_ready high; checks latency, payload, tags and the done pulse.
  task automatic collect(input int first, input logic [8:0] e0, input logic [8:0] e1,
                         input logic [8:0] e2, input logic [8:0] e3);
    logic [8:0] ev [4];
    int n;
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    for (int r = first; r < 4; r++) begin
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("latency", n, 2);
      chk("out_data", out_data, ev[r]);
      chk("out_row", out_row, r / 2);
      chk("out_col", out_col, r % 2);
      chk("busy_run", busy, 1);
      chk("no_done", done, 0);
      @(negedge clk);
    end
    chk("done_rise", done, 1);
    chk("busy_fall", busy, 0);
    chk("valid_drop", out_valid, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    ena       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_ready", in_ready, 0);

`ifdef MATMUL_SIGNED_EN
    // A = {-1,2,3,-4}, B = identity
    load(16'hC32F, 16'h1001);
    collect(0, 9'h1FF, 9'h002, 9'h003, 9'h1FC);
`else
    // A = {1,2,3,4}, B = {5,6,7,8}
    load(16'h4321, 16'h8765);
    collect(0, 9'd19, 9'd22, 9'd43, 9'd50);

    load(16'hFFFF, 16'hFFFF);
    collect(0, 9'd450, 9'd450, 9'd450, 9'd450);

    // Output backpressure on the first result
    out_ready = 1'b0;
    load(16'h4321, 16'h8765);
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 19);
      chk("bp_row", out_row, 0);
      chk("bp_col", out_col, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drop", out_valid, 0);
    collect(1, 9'd19, 9'd22, 9'd43, 9'd50);

    // Load stalls, ignored start and ena freeze
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1; a_in = 4'd1; b_in = 4'd5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_ready", in_ready, 1);
    in_valid = 1'b1; start = 1'b1; a_in = 4'd2; b_in = 4'd6;
    @(negedge clk);
    start = 1'b0; ena = 1'b0; a_in = 4'd15; b_in = 4'd15;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("ena_ready", in_ready, 0);
      chk("ena_busy", busy, 1);
      @(negedge clk);
    end
    ena = 1'b1; a_in = 4'd3; b_in = 4'd7;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; a_in = 4'd4; b_in = 4'd8;
    @(negedge clk);
    in_valid = 1'b0;
    chk("load_end_ready", in_ready, 0);
    chk("load_end_busy", busy, 1);
    collect(0, 9'd19, 9'd22, 9'd43, 9'd50);

    // Reset in the middle of COMPUTE, then a clean rerun
    load(16'h4321, 16'h8765);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_row", out_row, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load(16'h4321, 16'h8765);
    collect(0, 9'd19, 9'd22, 9'd43, 9'd50);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
